// File: rtl/core_load_ctrl.sv
// Initiator-side load/unload sequencer for one sat_engine bin.
// Optional macro CORE_LOAD_SKIP_UNSAT_EN: an unsat result skips the clause writeback.
module core_load_ctrl #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start_i,
    input  logic [WIDTH_BIN_ID-1:0]                    bin_id_i,
    input  logic [WIDTH_LVL-1:0]                       load_lvl_i,
    input  logic [WIDTH_LVL-1:0]                       base_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]       vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]       lvl_states_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       sat_o,
    output logic                                       unsat_o,
    output logic [WIDTH_LVL-1:0]                       bkt_lvl_o,
    output logic                                       mem_rd_o,
    output logic                                       mem_wr_o,
    output logic [WIDTH_BIN_ID+$clog2(NUM_CLAUSES)-1:0] mem_addr_o,
    input  logic [2*NUM_VARS-1:0]                      mem_rdata_i,
    output logic [2*NUM_VARS-1:0]                      mem_wdata_o,
    output logic [NUM_CLAUSES-1:0]                     wr_carray_o,
    output logic [2*NUM_VARS-1:0]                      clause_o,
    output logic [NUM_VARS-1:0]                        wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]       vars_states_o,
    output logic [NUM_LVLS-1:0]                        wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]       lvl_states_o,
    output logic                                       start_core_o,
    output logic [WIDTH_LVL-1:0]                       cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                       load_lvl_o,
    output logic                                       base_lvl_en_o,
    output logic [WIDTH_LVL-1:0]                       base_lvl_o,
    input  logic                                       done_core_i,
    input  logic                                       sat_i,
    input  logic                                       unsat_i,
    input  logic [WIDTH_LVL-1:0]                       bkt_lvl_i,
    output logic [NUM_CLAUSES-1:0]                     rd_carray_o,
    input  logic [2*NUM_VARS-1:0]                      clause_i,
    output logic [2:0]                                 state_o
);
    localparam int RW = $clog2(NUM_CLAUSES);

    typedef enum logic [2:0] {
        IDLE, LOAD_C, LOAD_VS, LOAD_LS, START, RUN, UNLOAD, FINISH
    } state_t;

    state_t                  state, state_nx;
    logic [RW-1:0]           row;
    logic                    tail;
    logic [WIDTH_BIN_ID-1:0] bin;
    logic [WIDTH_LVL-1:0]    load_lvl, base_lvl, bkt_lvl;
    logic                    sat, unsat;
    logic [RW-1:0]           prev_row;
    logic                    prev_vld;
    logic                    skip_unload;

    // The second half of each row transfer trails the first by one cycle;
    // tail marks the extra cycle after the last row was issued.
    assign prev_row = tail ? row : row - RW'(1);
    assign prev_vld = tail || (row != '0);

`ifdef CORE_LOAD_SKIP_UNSAT_EN
    assign skip_unload = unsat_i;
`else
    assign skip_unload = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            row      <= '0;
            tail     <= 1'b0;
            bin      <= '0;
            load_lvl <= '0;
            base_lvl <= '0;
            bkt_lvl  <= '0;
            sat      <= 1'b0;
            unsat    <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        bin      <= bin_id_i;
                        load_lvl <= load_lvl_i;
                        base_lvl <= base_lvl_i;
                        sat      <= 1'b0;
                        unsat    <= 1'b0;
                        bkt_lvl  <= '0;
                    end
                end
                LOAD_C, UNLOAD: begin
                    if (tail) begin
                        tail <= 1'b0;
                        row  <= '0;
                    end else if (row == RW'(NUM_CLAUSES - 1)) begin
                        tail <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end
                RUN: begin
                    if (done_core_i) begin
                        sat     <= sat_i;
                        unsat   <= unsat_i;
                        bkt_lvl <= bkt_lvl_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_i) state_nx = LOAD_C;
            LOAD_C:  if (tail) state_nx = LOAD_VS;
            LOAD_VS: state_nx = LOAD_LS;
            LOAD_LS: state_nx = START;
            START:   state_nx = RUN;
            RUN:     if (done_core_i) state_nx = skip_unload ? FINISH : UNLOAD;
            UNLOAD:  if (tail) state_nx = FINISH;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_rd_o        = 1'b0;
        mem_wr_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        wr_carray_o     = '0;
        clause_o        = '0;
        wr_var_states_o = '0;
        vars_states_o   = '0;
        wr_lvl_states_o = '0;
        lvl_states_o    = '0;
        start_core_o    = 1'b0;
        base_lvl_en_o   = 1'b0;
        rd_carray_o     = '0;
        done_o          = 1'b0;
        case (state)
            LOAD_C: begin
                if (!tail) begin
                    mem_rd_o   = 1'b1;
                    mem_addr_o = {bin, row};
                end
                if (prev_vld) begin
                    wr_carray_o = NUM_CLAUSES'(1) << prev_row;
                    clause_o    = mem_rdata_i;
                end
            end
            LOAD_VS: begin
                wr_var_states_o = '1;
                vars_states_o   = vars_states_i;
            end
            LOAD_LS: begin
                wr_lvl_states_o = '1;
                lvl_states_o    = lvl_states_i;
            end
            START: begin
                start_core_o  = 1'b1;
                base_lvl_en_o = 1'b1;
            end
            UNLOAD: begin
                if (!tail) rd_carray_o = NUM_CLAUSES'(1) << row;
                if (prev_vld) begin
                    mem_wr_o    = 1'b1;
                    mem_addr_o  = {bin, prev_row};
                    mem_wdata_o = clause_i;
                end
            end
            FINISH: done_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o        = (state != IDLE);
    assign sat_o         = sat;
    assign unsat_o       = unsat;
    assign bkt_lvl_o     = bkt_lvl;
    assign cur_bin_num_o = WIDTH_LVL'(bin);
    assign load_lvl_o    = load_lvl;
    assign base_lvl_o    = base_lvl;
    assign state_o       = state;
endmodule

// File: doc/core_load_ctrl.md
Name: core_load_ctrl

Overview:
- Initiator-side controller for `sat_engine`'s load/unload interface.
- Fetches one bin of clauses from bin memory and writes them row by row into the engine's clause array. It then writes the var-state and lvl-state lists, pulses start with base level, and waits for the engine's done.
- After done, reads the updated clause array back and writes it to the same bin memory rows.
- Sits between the global bin manager and one `sat_engine` instance.

Parameters:
- NUM_CLAUSES, 8, clause rows per bin; must be a power of two.
- NUM_VARS, 8, variables per bin; clause word width is 2*NUM_VARS.
- NUM_LVLS, 8, level-state entries.
- WIDTH_BIN_ID, 10, bin identifier width.
- WIDTH_LVL, 16, decision level width.
- WIDTH_VAR_STATES, 19, bits per var-state entry.
- WIDTH_LVL_STATES, 11, bits per lvl-state entry.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start_i  in  1  request to process one bin; accepted only in IDLE
- bin_id_i  in  WIDTH_BIN_ID  bin to load; latched on accept
- load_lvl_i  in  WIDTH_LVL  load level; latched on accept
- base_lvl_i  in  WIDTH_LVL  base level; latched on accept
- vars_states_i  in  WIDTH_VAR_STATES*NUM_VARS  var-state list; sampled in LOAD_VS
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  lvl-state list; sampled in LOAD_LS
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse in FINISH
- sat_o  out  1  engine sat result; held until next accept
- unsat_o  out  1  engine unsat result; held until next accept
- bkt_lvl_o  out  WIDTH_LVL  engine backtrack level; held until next accept
- mem_rd_o  out  1  bin memory read strobe; read data arrives the next cycle
- mem_wr_o  out  1  bin memory write strobe
- mem_addr_o  out  WIDTH_BIN_ID+$clog2(NUM_CLAUSES)  equals {bin_id, row}
- mem_rdata_i  in  2*NUM_VARS  clause read data
- mem_wdata_o  out  2*NUM_VARS  clause write data
- wr_carray_o  out  NUM_CLAUSES  one-hot clause-row write to engine
- clause_o  out  2*NUM_VARS  clause data to engine
- wr_var_states_o  out  NUM_VARS  all-ones pulse writes the var-state list
- vars_states_o  out  WIDTH_VAR_STATES*NUM_VARS  var-state data to engine
- wr_lvl_states_o  out  NUM_LVLS  all-ones pulse writes the lvl-state list
- lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS  lvl-state data to engine
- start_core_o  out  1  one-cycle engine start
- cur_bin_num_o  out  WIDTH_LVL  zero-extended latched bin_id
- load_lvl_o  out  WIDTH_LVL  latched load level
- base_lvl_en_o  out  1  one-cycle strobe, concurrent with start_core_o
- base_lvl_o  out  WIDTH_LVL  latched base level
- done_core_i  in  1  engine done
- sat_i  in  1  engine sat result
- unsat_i  in  1  engine unsat result
- bkt_lvl_i  in  WIDTH_LVL  engine backtrack level
- rd_carray_o  out  NUM_CLAUSES  one-hot clause-row read from engine
- clause_i  in  2*NUM_VARS  engine clause data; valid the cycle after rd_carray_o

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; every output, row counter and latch is zero.
- States: IDLE -> LOAD_C -> LOAD_VS -> LOAD_LS -> START -> RUN -> UNLOAD -> FINISH -> IDLE.
- IDLE:
  - start_i=1 latches bin_id_i, load_lvl_i and base_lvl_i.
  - Clears sat_o, unsat_o and bkt_lvl_o.
  - Moves to LOAD_C.
- LOAD_C, N+1 cycles where N=NUM_CLAUSES:
  - Cycle k (k<N): mem_rd_o=1, mem_addr_o={bin,k}.
  - Cycle k+1 (k<N): wr_carray_o[k]=1, clause_o=mem_rdata_i.
  - Reads and writes overlap.
- LOAD_VS, 1 cycle: wr_var_states_o all ones, vars_states_o=vars_states_i.
- LOAD_LS, 1 cycle: wr_lvl_states_o all ones, lvl_states_o=lvl_states_i.
- START, 1 cycle: start_core_o=1 and base_lvl_en_o=1. For N=8, this is the 12th cycle after the accept edge.
- RUN: waits for done_core_i. On done_core_i, latches sat_i, unsat_i and bkt_lvl_i, then moves to UNLOAD.
- UNLOAD, N+1 cycles:
  - Cycle k (k<N): rd_carray_o[k]=1.
  - Cycle k+1 (k<N): mem_wr_o=1, mem_addr_o={bin,k}, mem_wdata_o=clause_i.
- FINISH: done_o=1 for one cycle, then IDLE.
- Boundary rules:
  - start_i outside IDLE is ignored.
  - done_core_i outside RUN is ignored.
  - done_core_i arriving in the first RUN cycle is accepted.
  - mem_rd_o and mem_wr_o are never high in the same cycle.
  - At most one bit of wr_carray_o or rd_carray_o is high in any cycle.
  - Row counter is $clog2(N) bits; the last-row flag is held separately, so there is no wrap.
  - Reset mid-operation drops all strobes immediately, returns to IDLE and performs no partial writeback.
  - start_i asserted during FINISH is ignored; it is accepted on the next IDLE cycle.

Optional Feature:
- Macro: CORE_LOAD_SKIP_UNSAT_EN.
- Defined: if the latched unsat is 1, RUN goes directly to FINISH. No rd_carray_o strobes and no memory writes occur.
- Undefined: UNLOAD always runs.

Test Plan:
- Load bin_id=3 with row k data 16'h0100+k → wr_carray_o one-hot bit k carries 16'h0100+k. Read addresses are 24..31.
- Load complete → wr_var_states_o=8'hff and wr_lvl_states_o=8'hff, one cycle each. The start_core_o pulse carries base_lvl_o=2 and load_lvl_o=3.
- Engine done with sat_i=1 and clause_i=16'hA5A5+row → mem_wr_o writes addresses 24..31. done_o pulses once; sat_o=1 is held.
- Engine done with unsat_i=1 and bkt_lvl_i=1 → unsat_o=1 and bkt_lvl_o=1. With the macro defined, no mem_wr_o occurs; without it, 8 writes occur.
- start_i pulsed during RUN → ignored, no state change. Then rst=0 asserted mid-UNLOAD → all outputs 0 immediately, state IDLE.
- Back-to-back runs with bin_id=0 then bin_id=1023 → addresses 0..7, then 8184..8191.
